// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared encodings and width default for the multiply/divide unit
package md_defs;

   localparam int MD_W = 32;

   typedef enum logic [2:0] {
      MD_NOP   = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - request/result bundle between execute-stage control and md_unit
interface md_unit_if #(parameter int W = md_defs::MD_W);

   logic         start;
   logic [2:0]   md_op;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cancel;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   modport master (
      output start, md_op, op_a, op_b, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, md_op, op_a, op_b, cancel,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/md_unit_div_step.sv
// rtl/md_unit_div_step.sv - one restoring-divide iteration
module md_div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   part_rem,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] next_rem,
   output logic         q_bit
);

   logic [W-1:0] diff;

   // Subtract when the shifted remainder covers the divisor; otherwise restore.
   // The W-bit difference is exact whenever it is kept because the result is below the divisor.
   always_comb begin
      q_bit    = (part_rem >= {1'b0, divisor});
      diff     = part_rem[W-1:0] - divisor;
      next_rem = q_bit ? diff : part_rem[W-1:0];
   end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit with architectural HI/LO
module md_unit
   import md_defs::*;
#(
   parameter int W = MD_W
) (
   input logic       clk,
   input logic       rst_n,
   md_unit_if.slave  bus
);

   localparam int CW = $clog2(W);

   md_state_e      st_q, st_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   m_q, m_d;
   logic           is_div_q, is_div_d;
   logic           neg_res_q, neg_res_d;
   logic           neg_rem_q, neg_rem_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           mul_op, div_op, signed_op, a_neg, b_neg;
   logic [W-1:0]   a_mag, b_mag;
   logic [W:0]     mul_sum;
   logic [W-1:0]   div_rem;
   logic           div_qbit;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix, rem_fix;

   // Accumulator upper half plus the next dividend bit forms the partial remainder.
   md_div_step #(.W(W)) u_div_step (
      .part_rem ({acc_q[2*W-1:W], acc_q[W-1]}),
      .divisor  (m_q),
      .next_rem (div_rem),
      .q_bit    (div_qbit)
   );

   // Operand decode/magnitudes, the shift-add multiply step and the final sign fix-up.
   always_comb begin
      mul_op    = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);
      div_op    = (bus.md_op == MD_DIV)  || (bus.md_op == MD_DIVU);
      signed_op = (bus.md_op == MD_MULT) || (bus.md_op == MD_DIV);
      a_neg     = signed_op & bus.op_a[W-1];
      b_neg     = signed_op & bus.op_b[W-1];
      a_mag     = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
      b_mag     = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;
      mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? m_q : {W{1'b0}})};
      prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
      quo_fix   = neg_res_q ? (~acc_q[W-1:0] + 1'b1) : acc_q[W-1:0];
      rem_fix   = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
   end

   // Next-state logic: IDLE accepts work, RUN iterates W times, FIX commits HI/LO.
   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      m_d       = m_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (bus.start && !bus.cancel) begin
               if (mul_op || div_op) begin
                  st_d      = ST_RUN;
                  busy_d    = 1'b1;
                  cnt_d     = CW'(W - 1);
                  is_div_d  = div_op;
                  acc_d     = {{W{1'b0}}, (div_op ? a_mag : b_mag)};
                  m_d       = div_op ? b_mag : a_mag;
                  // A zero divisor yields an all-ones quotient regardless of operand signs.
                  neg_res_d = (a_neg ^ b_neg) & ~(div_op && (bus.op_b == {W{1'b0}}));
                  neg_rem_d = div_op & a_neg;
               end else if (bus.md_op == MD_MTHI) begin
                  hi_d = bus.op_a;
               end else if (bus.md_op == MD_MTLO) begin
                  lo_d = bus.op_a;
               end
            end
         end
         ST_RUN: begin
            if (bus.cancel) begin
               st_d   = ST_IDLE;
               busy_d = 1'b0;
            end else begin
               acc_d = is_div_q ? {div_rem, acc_q[W-2:0], div_qbit}
                                : {mul_sum, acc_q[W-1:1]};
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) st_d = ST_FIX;
            end
         end
         ST_FIX: begin
            st_d   = ST_IDLE;
            busy_d = 1'b0;
            if (!bus.cancel) begin
               done_d = 1'b1;
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*W-1:W];
                  lo_d = prod_fix[W-1:0];
               end
            end
         end
         default: begin
            st_d   = ST_IDLE;
            busy_d = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs; reset clears everything with no partial write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q      <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         m_q       <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         m_q       <= m_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;

   localparam int W = 32;

   typedef struct {
      int unsigned cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic        clk;
   logic        rst_n;
   int unsigned cyc;
   int          checks;
   int          errors;
   exp_t        sb[$];
   exp_t        got;
   logic [31:0] mhi, mlo;

   md_unit_if #(.W(W)) bus ();

   md_unit #(.W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", nm, act, want);
      end
   endtask

   // Monitor: every done pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got hi=%h lo=%h want=no done", bus.hi, bus.lo);
         end else begin
            got = sb.pop_front();
            chk("done_cycle", 64'(cyc), 64'(got.cyc));
            chk("hi", 64'(bus.hi), 64'(got.hi));
            chk("lo", 64'(bus.lo), 64'(got.lo));
         end
      end
   end

   // Drives one request for a single cycle; returns one cycle after the start cycle.
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_done, input logic [31:0] eh, input logic [31:0] el);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.md_op = op;
      bus.op_a  = a;
      bus.op_b  = b;
      if (expect_done) begin
         sb.push_back('{cyc: cyc + 34, hi: eh, lo: el});
         mhi = eh;
         mlo = el;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op_a  = $urandom;
      bus.op_b  = $urandom;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      chk("drain_pending", 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit chk_busy);
      issue(op, a, b, 1'b1, eh, el);
      if (chk_busy) begin
         for (int i = 1; i <= 34; i++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", i), 64'(bus.busy), (i <= 33) ? 64'd1 : 64'd0);
         end
      end
      drain();
   endtask

   task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
      issue(3'd5, h, 32'h0, 1'b0, 32'h0, 32'h0);
      issue(3'd6, l, 32'h0, 1'b0, 32'h0, 32'h0);
      mhi = h;
      mlo = l;
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      mhi          = '0;
      mlo          = '0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.md_op    = 3'd0;
      bus.op_a     = '0;
      bus.op_b     = '0;
      bus.cancel   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      rst_n = 1'b1;

      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b1);
      run_op(3'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
      run_op(3'd1, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0);
      run_op(3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_op(3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      run_op(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run_op(3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
      run_op(3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0);
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

      issue(3'd5, 32'h1234, 32'h0, 1'b0, 32'h0, 32'h0);
      chk("mthi_hi", 64'(bus.hi), 64'h1234);
      chk("mthi_lo", 64'(bus.lo), 64'(mlo));
      chk("mthi_busy", 64'(bus.busy), 64'd0);
      chk("mthi_done", 64'(bus.done), 64'd0);
      mhi = 32'h1234;

      issue(3'd1, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.md_op = 3'd6;
      bus.op_a  = 32'hDEAD;
      @(posedge clk); #1;
      bus.start = 1'b0;
      drain();

      issue(3'd7, 32'h5A5A, 32'h1, 1'b0, 32'h0, 32'h0);
      chk("op7_busy", 64'(bus.busy), 64'd0);
      chk("op7_hi", 64'(bus.hi), 64'(mhi));
      chk("op7_lo", 64'(bus.lo), 64'(mlo));

      @(posedge clk); #1;
      bus.cancel = 1'b1;
      bus.start  = 1'b1;
      bus.md_op  = 3'd5;
      bus.op_a   = 32'hBEEF;
      @(posedge clk); #1;
      bus.md_op  = 3'd1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.cancel = 1'b0;
      chk("idle_cancel_hi", 64'(bus.hi), 64'(mhi));
      chk("idle_cancel_busy", 64'(bus.busy), 64'd0);

      set_hilo(32'hAAAA, 32'hAAAA);
      issue(3'd1, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0);
      repeat (9) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      chk("cancel_run_busy", 64'(bus.busy), 64'd0);
      repeat (40) @(posedge clk);
      #1;
      chk("cancel_run_hi", 64'(bus.hi), 64'hAAAA);
      chk("cancel_run_lo", 64'(bus.lo), 64'hAAAA);

      set_hilo(32'h5555, 32'h5555);
      issue(3'd2, 32'd2, 32'd3, 1'b0, 32'h0, 32'h0);
      repeat (32) @(posedge clk);
      #1;
      chk("fix_busy_before", 64'(bus.busy), 64'd1);
      bus.cancel = 1'b1;
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      chk("cancel_fix_busy", 64'(bus.busy), 64'd0);
      chk("cancel_fix_done", 64'(bus.done), 64'd0);
      chk("cancel_fix_hi", 64'(bus.hi), 64'h5555);
      chk("cancel_fix_lo", 64'(bus.lo), 64'h5555);

      issue(3'd3, 32'd100, 32'd3, 1'b0, 32'h0, 32'h0);
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(bus.busy), 64'd0);
      chk("rst_mid_done", 64'(bus.done), 64'd0);
      chk("rst_mid_hi", 64'(bus.hi), 64'd0);
      chk("rst_mid_lo", 64'(bus.lo), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
      chk("post_rst_lo", 64'(bus.lo), 64'd0);
      chk("final_pending", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers.
- Sits in the execute stage, directly downstream of the decode control unit. It consumes the MULT/MULTU/DIV/DIVU/MTHI/MTLO decodes (AluMul/AluDiv class) and supplies HI/LO to MFHI/MFLO.
- Asserts busy so the hazard logic stalls younger HI/LO users until the result is committed.

Parameters:
- W, 32, operand/HI/LO width; iteration count equals W.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request valid in this cycle; only accepted when busy=0.
- md_op  input  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP).
- op_a  input  W  rs value (multiplicand/dividend, or MTHI/MTLO data).
- op_b  input  W  rt value (multiplier/divisor).
- cancel  input  1  pipeline flush; aborts an in-flight operation.
- busy  output  1  operation in progress; stall any HI/LO access.
- done  output  1  one-cycle pulse; HI/LO hold the new result this cycle.
- hi  output  W  HI register (drives MFHI).
- lo  output  W  LO register (drives MFLO).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; internal accumulators=0.
- FSM states and transitions:
  - IDLE -> RUN when start=1 and md_op is 1..4.
  - RUN: W cycles, one iteration per cycle, iteration counter from W-1 down to 0. Goes to FIX after the last iteration.
  - FIX: one cycle; sign correction and HI/LO write. Goes to IDLE.
- Latency: start accepted in cycle 0; busy=1 in cycles 1..W+1; done=1 and busy=0 in cycle W+2. For W=32, done is in cycle 34.
- Operand capture: op_a, op_b and the signed flag are latched in cycle 0. Later input changes have no effect.
- Signed ops (MULT, DIV): operands are converted to magnitudes at capture. In FIX:
  - product is negated if sign(a) XOR sign(b);
  - quotient is negated if sign(a) XOR sign(b);
  - remainder takes the sign of the dividend.
- Multiply: shift-add over a 2W-bit accumulator. HI = product[2W-1:W], LO = product[W-1:0].
- Divide: restoring, one quotient bit per cycle. LO = quotient, HI = remainder.
- Divide by zero: no exception; completes with normal latency. LO = all ones, HI = op_a, for both DIV and DIVU.
- Signed overflow (DIV 0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0.
- MTHI/MTLO with busy=0: the selected register is written at the next edge. No busy, no done; the other register is unchanged.
- start while busy=1: ignored entirely, including MTHI/MTLO. Upstream must stall on busy.
- start with md_op 0 or 7: no effect.
- cancel=1 in any non-IDLE state: next state is IDLE, busy=0 next cycle, no done, HI/LO unchanged.
- cancel=1 in IDLE together with start: the start is dropped.
- cancel has priority over the FIX write: cancel asserted during FIX suppresses the write and the done pulse.
- hi/lo are direct register outputs. They never show partial results; they change only on the FIX->IDLE edge or on an MTHI/MTLO write.
- Reset asserted mid-operation: immediate return to reset values, with no partial write.

Decomposition:
- Shared package md_defs holds:
  - md_op encodings (MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - FSM state encodings (ST_IDLE, ST_RUN, ST_FIX);
  - the W default.
- The decode control unit imports the same op encodings to drive md_op.
- One sub-module, md_div_step: combinational restoring-divide step (partial remainder, divisor -> next remainder, quotient bit), instantiated once.
- The multiply step stays inline in md_unit.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done in cycle 34; HI=0xFFFFFFFE, LO=0x00000001; busy high in cycles 1..33.
- MULT 0xFFFFFFFE(-2) x 0x00000003 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV -7/2 (0xFFFFFFF9, 0x00000002) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 when idle -> hi=0x1234 next cycle, lo unchanged, busy/done stay 0. MTLO issued during a busy MULT -> ignored; MULT result stands.
- MULT started with HI=LO=0xAAAA, cancel in cycle 10 -> busy=0 in cycle 11, no done, HI/LO remain 0xAAAA. Async reset mid-DIV -> all outputs 0 immediately.
